step_risc_core: RTL
===================

Name: step_risc_core

Overview:
- Parametrised successor to the team's 8-bit, four-register multicycle teaching CPU.
- Keeps the 8-bit ISA: ADD, SUB, LOAD, STORE, JLEZ, JALR, HALT, LUI, LLI.
- Adds configurable memory depth, a configurable state-advance prescaler, and a memory-mapped LED register at a configurable address.
- Adds run/single-step/halt control, an external program-load port while stopped, a proper synchronous reset, and debug/instruction-count outputs.

Parameters:
- MEM_AW, 8, memory address width. Depth is 2^MEM_AW bytes; legal range 4..8. Register-supplied addresses use their low MEM_AW bits.
- PRESCALE_W, 11, prescaler width. Tick every 2^PRESCALE_W clocks; 0 = tick every clock.
- IO_ADDR, 255, memory address mirrored onto led (must be < 2^MEM_AW).

Ports:
- CLK_12MHz  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- run  in  1  level; 1 = free-run on ticks
- step  in  1  one-clock pulse; execute exactly one instruction while run=0
- load_we  in  1  program-load write strobe
- load_addr  in  MEM_AW  load address
- load_data  in  8  load data
- dbg_sel  in  2  register select for dbg_reg (0=A, 1=B, 2=C, 3=D)
- led  out  8  copy of mem[IO_ADDR]
- halted  out  1  HALT executed
- busy  out  1  an instruction is in progress
- pc_dbg  out  MEM_AW  current PC
- dbg_reg  out  8  selected register, combinational
- instr_count  out  16  retired instructions, wraps at 0xFFFF

Behaviour:
- Reset (synchronous, active-high): PC=0; A=B=C=D=0; state=IDLE; prescaler=0; led=0; halted=0; busy=0; instr_count=0. Memory contents are preserved. RESET aborts any in-progress instruction with no register or memory write.
- Tick: prescaler counts every clock; tick=1 when count==0. All state transitions except IDLE->FETCH happen only on a tick.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE: start an instruction (->FETCH, busy=1) on a tick when run=1, or when a step has been armed.
  - step pulse with run=0, not halted, in IDLE arms one instruction; a step pulse at any other time is ignored.
  - run=1 takes precedence; a simultaneous step is not armed.
- FETCH: IR <= mem[PC]; PC <= PC+1 (wraps modulo 2^MEM_AW).
- DECODE: latch Rrd, Rrs, Rrt from IR fields rd=IR[3:2], rs=IR[1:0], rt=IR[5:4]; imm=IR[3:0].
- EXECUTE by IR[7:4]:
  - 0 ADD: res = Rrd+Rrs, mod 256.
  - 1 SUB: res = Rrd-Rrs, mod 256.
  - 2 LOAD: res = mem[Rrs].
  - 3 STORE: mem[Rrs] <= Rrd; if address==IO_ADDR, led <= Rrd. Retire.
  - 4 JLEZ: if Rrs==0 or Rrs[7]==1, PC <= Rrd. Retire.
  - 5 JALR: res = PC (already incremented); PC <= Rrd.
  - 7 HALT: -> HALTED, halted=1.
  - 6: NOP, retire.
  - 8..B LUI: res = {imm, Rrt[3:0]}.
  - C..F LLI: res = {Rrt[7:4], imm}.
- WRITEBACK:
  - ADD/SUB/LOAD write rd.
  - LUI/LLI write rt.
  - JALR writes rs. If rs==rd, the jump target is still the pre-write Rrd.
  - Retire.
- Retire: instr_count += 1; busy=0; ->IDLE. HALT also counts as retired when entering HALTED.
- Tick latencies: ADD/SUB/LOAD/JALR/LUI/LLI = 4 ticks; STORE/JLEZ/NOP/HALT = 3 ticks.
- run dropping mid-instruction: the instruction completes, then the core stays in IDLE.
- HALTED: no further execution; only RESET exits.
- Load port:
  - load_we honoured only when state is IDLE with run=0, or HALTED; ignored otherwise.
  - Writes mem[load_addr] in the same clock.
  - A load write to IO_ADDR also updates led.

Test Plan:
- PRESCALE_W=0. Load mem[0..2] = A5, E3, 70; run=1. -> C=0x53, halted=1, instr_count=3, pc_dbg=3. HALT reached after 4+4+3 clocks from the first FETCH.
- LUI/LLI chain:
  - Program C7, 8F, DF, 9F, 31, 70.
  - Result: A=0xF7, B=0xFF, mem[255]=0xF7, led=0xF7.
  - The STORE takes 3 ticks.
- JLEZ with Rrs=0x80 (negative) jumps to Rrd. With Rrs=0x01 it falls through to PC+1. With Rrs=0x00 it jumps.
- JALR: C=0x10 and 0x5A at address 5. -> PC=0x10 and C=0x06 after WRITEBACK.
- Step and load control:
  - run=0, a step pulse executes exactly one instruction; instr_count increments by 1 and the core returns to IDLE.
  - A second pulse while busy is ignored.
  - load_we while run=1 leaves memory unchanged.
- RESET asserted during EXECUTE of an ADD: no register change; PC=0; state=IDLE; memory intact. PRESCALE_W=2: transitions only every 4th clock.

Source files
------------

// File: rtl/step_risc_core.sv
// step_risc_core: 8-bit, four-register multicycle CPU with run/step/halt
// control, a program-load port, a tick prescaler and a memory-mapped LED byte.
//
// Ports:
//   CLK_12MHz    system clock
//   RESET        synchronous active-high reset (memory contents survive it)
//   run          level, free-run on ticks
//   step         one-clock pulse, executes one instruction while run=0
//   load_we/load_addr/load_data  program-load write, honoured only while stopped
//   dbg_sel      register select for dbg_reg (0=A .. 3=D)
//   led          copy of mem[IO_ADDR]
//   halted       HALT executed
//   busy         an instruction is in progress
//   pc_dbg       current PC
//   dbg_reg      selected register (combinational)
//   instr_count  retired instructions, wraps
module step_risc_core #(
  parameter int MEM_AW     = 8,
  parameter int PRESCALE_W = 11,
  parameter int IO_ADDR    = 255
) (
  input  logic              CLK_12MHz,
  input  logic              RESET,
  input  logic              run,
  input  logic              step,
  input  logic              load_we,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic [1:0]        dbg_sel,
  output logic [7:0]        led,
  output logic              halted,
  output logic              busy,
  output logic [MEM_AW-1:0] pc_dbg,
  output logic [7:0]        dbg_reg,
  output logic [15:0]       instr_count
);

  localparam logic [MEM_AW-1:0] IO_A = MEM_AW'(IO_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  state_t            state;
  logic [MEM_AW-1:0] pc;
  logic [7:0]        ir, rrd, rrs, rrt, res;
  logic [7:0]        rf [4];
  logic [7:0]        mem [2**MEM_AW];
  logic [7:0]        pc_ext;
  logic              tick;
  logic              load_wr, store_wr;
  logic [MEM_AW-1:0] rs_addr;

  // Prescaler: tick on count==0, or every clock when the width is zero.
  if (PRESCALE_W == 0) begin : g_nopre
    assign tick = 1'b1;
  end else begin : g_pre
    logic [PRESCALE_W-1:0] presc;
    always_ff @(posedge CLK_12MHz) begin
      if (RESET) presc <= '0;
      else       presc <= presc + 1'b1;
    end
    assign tick = (presc == '0);
  end

  assign rs_addr = rrs[MEM_AW-1:0];

  always_comb begin
    pc_ext             = '0;
    pc_ext[MEM_AW-1:0] = pc;
  end

  // Loads only while the core is parked; a store is the EXECUTE-tick of op 3.
  assign load_wr  = load_we && ((state == S_IDLE && !run) || state == S_HALTED);
  assign store_wr = !RESET && tick && state == S_EXEC && ir[7:4] == 4'h3;

  // Memory is kept out of the reset path so its contents survive RESET.
  always_ff @(posedge CLK_12MHz) begin
    if (load_wr)       mem[load_addr] <= load_data;
    else if (store_wr) mem[rs_addr]   <= rrd;
  end

  assign pc_dbg  = pc;
  assign dbg_reg = rf[dbg_sel];

  always_ff @(posedge CLK_12MHz) begin
    if (RESET) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      rrd         <= '0;
      rrs         <= '0;
      rrt         <= '0;
      res         <= '0;
      led         <= '0;
      halted      <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      if (load_wr && load_addr == IO_A) led <= load_data;
      case (state)
        S_IDLE: begin
          // run wins over step; a step start is not tied to a tick.
          if ((run && tick) || (!run && step)) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: if (tick) begin
          ir    <= mem[pc];
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: if (tick) begin
          rrd   <= rf[ir[3:2]];
          rrs   <= rf[ir[1:0]];
          rrt   <= rf[ir[5:4]];
          state <= S_EXEC;
        end
        S_EXEC: if (tick) begin
          state <= S_WB;
          case (ir[7:4])
            4'h0: res <= rrd + rrs;
            4'h1: res <= rrd - rrs;
            4'h2: res <= mem[rs_addr];
            4'h3: begin
              if (rs_addr == IO_A) led <= rrd;
              state       <= S_IDLE;
              busy        <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end
            4'h4: begin
              if (rrs == 8'h00 || rrs[7]) pc <= rrd[MEM_AW-1:0];
              state       <= S_IDLE;
              busy        <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end
            4'h5: begin
              // Link value is the already-incremented PC.
              res <= pc_ext;
              pc  <= rrd[MEM_AW-1:0];
            end
            4'h6: begin
              state       <= S_IDLE;
              busy        <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end
            4'h7: begin
              state       <= S_HALTED;
              halted      <= 1'b1;
              busy        <= 1'b0;
              instr_count <= instr_count + 1'b1;
            end
            default: begin
              if (ir[6]) res <= {rrt[7:4], ir[3:0]};  // LLI
              else       res <= {ir[3:0], rrt[3:0]};  // LUI
            end
          endcase
        end
        S_WB: if (tick) begin
          case (ir[7:4])
            4'h0, 4'h1, 4'h2: rf[ir[3:2]] <= res;
            4'h5:             rf[ir[1:0]] <= res;
            default:          if (ir[7]) rf[ir[5:4]] <= res;
          endcase
          state       <= S_IDLE;
          busy        <= 1'b0;
          instr_count <= instr_count + 1'b1;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
